painel_rolagem_varredura: RTL
=============================

Name: painel_rolagem_varredura

Overview:
- Consumes the two slow divided clocks from the JK ripple divider: the fast tap is the column-scan tick, the slow tap is the scroll tick.
- Drives a multiplexed LED column matrix: one column active at a time, row pattern read from a small message buffer.
- Horizontal scroll offset advances on the scroll tick.
- Both ticks are treated as asynchronous inputs, synchronised and edge-detected into the single clk domain.

Parameters:
- NUM_COLS, 5, physical columns driven (one-hot col_sel width).
- ROWS, 7, rows per column (row_data / wr_data width).
- MSG_LEN, 16, message buffer depth in columns; must be >= NUM_COLS.
- SYNC_STAGES, 2, synchroniser flops per tick input (>= 2).
- BLANK_CYC, 2, clk cycles of blanking between columns (>= 1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tick_col_in  in  1  column-scan tick from divider fast tap; asynchronous.
- tick_rol_in  in  1  scroll tick from divider slow tap; asynchronous.
- enable  in  1  1 = scan active, 0 = display blanked.
- wr_valid  in  1  buffer write request.
- wr_ready  out  1  buffer write accepted this cycle when wr_valid & wr_ready.
- wr_addr  in  clog2(MSG_LEN)  buffer column address.
- wr_data  in  ROWS  row pattern for that column.
- col_sel  out  NUM_COLS  one-hot active column; all zero when blanked.
- row_data  out  ROWS  row pattern for the active column.
- frame_done  out  1  one-cycle pulse when column NUM_COLS-1 finishes.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - col_sel=0, row_data=0, frame_done=0, wr_ready=0.
  - Column index=0, scroll offset=0, scroll-pending=0, state IDLE.
  - Buffer contents are cleared to 0.
  - wr_ready rises the first cycle after reset deasserts.
- Tick conditioning:
  - Each tick input passes through SYNC_STAGES flops, then a rising-edge detector giving a one-clk pulse (col_p, rol_p).
  - Latency from input edge to pulse is SYNC_STAGES+1 clk cycles.
- State machine:
  - IDLE: col_sel=0, row_data=0. Go to BLANK when enable=1.
  - BLANK:
    - col_sel=0; lasts BLANK_CYC cycles.
    - In the last BLANK cycle, row_data latches buf[(offset+col) mod MSG_LEN].
    - Then go to DRIVE.
  - DRIVE:
    - col_sel = one-hot(col); holds until col_p.
    - On col_p: col increments, wrapping NUM_COLS-1 -> 0, and the state goes to BLANK.
    - When the wrap happens: frame_done pulses in that same cycle, and if scroll-pending is set, offset = (offset+1) mod MSG_LEN and scroll-pending clears.
- Scroll timing:
  - rol_p sets scroll-pending in any state.
  - The offset changes only at a frame wrap, so the image never tears mid-frame.
  - Multiple rol_p before a wrap collapse into one step.
- Dropped column ticks:
  - col_p during BLANK or IDLE is dropped, with no column advance.
- Write port:
  - wr_ready=1 in every cycle except reset and the BLANK latch cycle.
  - An accepted write updates buf[wr_addr] at the next edge.
  - A write to the column latched next is visible at the next latch, never mid-column.
  - wr_addr >= MSG_LEN: handshake completes and the data is discarded.
- enable deasserted:
  - Takes effect the next cycle: state goes to IDLE and outputs go to 0.
  - col, offset and scroll-pending are retained.
  - Re-enabling resumes at the retained col via BLANK.
- Simultaneous col_p and rol_p at the wrap: the pending flag is evaluated before the new rol_p. The new rol_p sets pending for the next frame.
- Reset mid-operation: all state returns to reset values in the next cycle, regardless of state.

Optional Feature:
- Macro: PAINEL_ATIVO_BAIXO_EN.
- Defined: col_sel and row_data are inverted at the output register, for common-anode panels. Reset and blank values become all ones.
- Undefined: outputs are active-high as described above.

Decomposition:
- Package painel_pkg holds:
  - the state enum (IDLE, BLANK, DRIVE);
  - default widths ROWS=7 and NUM_COLS=5;
  - a function for the modular address (offset+col) mod MSG_LEN.
- Sub-module sincroniza_borda (SYNC_STAGES parameter; synchroniser plus rising-edge pulse), instantiated twice.

Test Plan:
- Reset then idle: hold reset 3 cycles, enable=0, toggle ticks -> col_sel=0, row_data=0, frame_done=0, wr_ready=1 from the first post-reset cycle.
- Scan order: write buf[i]=i+1 for i=0..15, enable=1, 5 col ticks -> row_data sequence 1,2,3,4,5 on col_sel 00001..10000. Each column is preceded by 2 blank cycles; frame_done pulses once.
- Scroll at frame boundary: 3 rol ticks mid-frame -> offset stays 0 until the wrap, then becomes 1. The next frame shows 2,3,4,5,6.
- Offset wrap: 16 frames with one scroll each -> offset returns to 0. A frame at offset 14 shows 15,16,1,2,3.
- Write hazard: wr_valid held across the BLANK latch cycle -> wr_ready=0 only in that cycle. The write lands one cycle later, and the new data appears at the next latch of that address.
- Tick edge cases: col tick during BLANK -> no advance. Reset asserted while in DRIVE with col=3 -> next cycle col_sel=0, state IDLE, offset=0.

Source files
------------

// File: rtl/painel_pkg.sv
// Shared types and helpers for the scrolling LED column scanner.
// Optional build macro: PAINEL_ATIVO_BAIXO_EN (active-low panel outputs).
package painel_pkg;

  localparam int DEF_ROWS     = 7;
  localparam int DEF_NUM_COLS = 5;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } estado_t;

  function automatic int end_mod(
    input int off,
    input int col,
    input int len
  );
    return (off + col) % len;
  endfunction

endpackage

// File: rtl/sincroniza_borda.sv
// Multi-flop synchroniser for an asynchronous tick followed by a
// registered rising-edge detector producing a one-clk pulse.
module sincroniza_borda #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulso
);

  logic [SYNC_STAGES-1:0] sr;
  logic                   ant;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr    <= '0;
      ant   <= 1'b0;
      pulso <= 1'b0;
    end else begin
      sr    <= {sr[SYNC_STAGES-2:0], din};
      ant   <= sr[SYNC_STAGES-1];
      pulso <= sr[SYNC_STAGES-1] & ~ant;
    end
  end

endmodule

// File: rtl/painel_rolagem_varredura.sv
// Multiplexed LED column scanner with frame-aligned horizontal scroll.
// Define PAINEL_ATIVO_BAIXO_EN for common-anode (inverted) outputs.
module painel_rolagem_varredura
  import painel_pkg::*;
#(
  parameter int NUM_COLS    = DEF_NUM_COLS,
  parameter int ROWS        = DEF_ROWS,
  parameter int MSG_LEN     = 16,
  parameter int SYNC_STAGES = 2,
  parameter int BLANK_CYC   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tick_col_in,
  input  logic                       tick_rol_in,
  input  logic                       enable,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
  input  logic [ROWS-1:0]            wr_data,
  output logic [NUM_COLS-1:0]        col_sel,
  output logic [ROWS-1:0]            row_data,
  output logic                       frame_done
);

  localparam int AW = $clog2(MSG_LEN);
  localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int BW = $clog2(BLANK_CYC + 1);

`ifdef PAINEL_ATIVO_BAIXO_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic col_p;
  logic rol_p;

  sincroniza_borda #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sinc_col (
    .clk  (clk),
    .reset(reset),
    .din  (tick_col_in),
    .pulso(col_p)
  );

  sincroniza_borda #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sinc_rol (
    .clk  (clk),
    .reset(reset),
    .din  (tick_rol_in),
    .pulso(rol_p)
  );

  estado_t           st;
  estado_t           st_n;
  logic [CW-1:0]     col;
  logic [CW-1:0]     col_n;
  logic [AW-1:0]     off;
  logic [AW-1:0]     off_n;
  logic              pend;
  logic              pend_n;
  logic [BW-1:0]     bcnt;
  logic [BW-1:0]     bcnt_n;
  logic              wrap;
  logic              latch;
  logic              rdy;
  logic [AW-1:0]     rd_addr;
  logic [NUM_COLS-1:0] oh_n;
  logic [ROWS-1:0]   mem [MSG_LEN];

  assign rd_addr  = AW'(end_mod(int'(off), int'(col), MSG_LEN));
  assign latch    = (st == BLANK) && (bcnt == BW'(BLANK_CYC - 1));
  assign wr_ready = rdy & ~latch;
  assign oh_n     = NUM_COLS'(1) << col_n;

  always_comb begin
    st_n   = st;
    col_n  = col;
    off_n  = off;
    pend_n = pend | rol_p;
    bcnt_n = bcnt;
    wrap   = 1'b0;
    if (!enable) begin
      st_n = IDLE;
    end else begin
      unique case (st)
        IDLE: begin
          st_n   = BLANK;
          bcnt_n = '0;
        end
        BLANK: begin
          if (latch) st_n = DRIVE;
          else bcnt_n = bcnt + 1'b1;
        end
        DRIVE: begin
          if (col_p) begin
            st_n   = BLANK;
            bcnt_n = '0;
            if (col == CW'(NUM_COLS - 1)) begin
              col_n = '0;
              wrap  = 1'b1;
              // pending is consumed before a coincident rol_p re-arms it
              pend_n = rol_p;
              if (pend) begin
                off_n = (off == AW'(MSG_LEN - 1)) ? '0 : off + 1'b1;
              end
            end else begin
              col_n = col + 1'b1;
            end
          end
        end
        default: st_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= IDLE;
      col        <= '0;
      off        <= '0;
      pend       <= 1'b0;
      bcnt       <= '0;
      rdy        <= 1'b0;
      frame_done <= 1'b0;
      col_sel    <= {NUM_COLS{INV}};
      row_data   <= {ROWS{INV}};
      for (int i = 0; i < MSG_LEN; i++) mem[i] <= '0;
    end else begin
      st         <= st_n;
      col        <= col_n;
      off        <= off_n;
      pend       <= pend_n;
      bcnt       <= bcnt_n;
      rdy        <= 1'b1;
      frame_done <= wrap;
      col_sel    <= {NUM_COLS{INV}} ^ ((st_n == DRIVE) ? oh_n : '0);
      if (st_n != DRIVE) row_data <= {ROWS{INV}};
      else if (latch) row_data <= {ROWS{INV}} ^ mem[rd_addr];
      if (wr_valid && wr_ready && (int'(wr_addr) < MSG_LEN)) begin
        mem[wr_addr] <= wr_data;
      end
    end
  end

endmodule
